// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier with a start/done four-phase handshake.
// It retires two multiplier bits per cycle and has a per-operation signed/unsigned mode.
module booth_mult_r4 #(
  parameter int unsigned D_IN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sgn,
  input  logic [D_IN-1:0]   mul_A,
  input  logic [D_IN-1:0]   mul_B,
  output logic              busy,
  output logic              done,
  output logic [2*D_IN-1:0] Product
);

  localparam int unsigned EW = (D_IN + 2) / 2 * 2;
  localparam int unsigned N  = EW / 2;
  localparam int unsigned AW = 2 * EW + 2;
  localparam int unsigned HW = EW + 2;
  localparam int unsigned PW = 2 * D_IN;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] mcand_q, mcand_d;
  logic [EW:0]   mplier_q, mplier_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [PW-1:0] product_q, product_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [EW-1:0] a_ext, b_ext;
  logic [HW-1:0] a1, a2, pp, sum_hi;
  logic [AW-1:0] acc_sh;

  // Booth step: add the selected partial product to the top, then shift right by 2.
  always_comb begin
    a_ext = sgn ? {{(EW-D_IN){mul_A[D_IN-1]}}, mul_A} : {{(EW-D_IN){1'b0}}, mul_A};
    b_ext = sgn ? {{(EW-D_IN){mul_B[D_IN-1]}}, mul_B} : {{(EW-D_IN){1'b0}}, mul_B};
    a1    = {{2{mcand_q[EW-1]}}, mcand_q};
    a2    = {a1[HW-2:0], 1'b0};
    case (mplier_q[2:0])
      3'b001, 3'b010: pp = a1;
      3'b011:         pp = a2;
      3'b100:         pp = -a2;
      3'b101, 3'b110: pp = -a1;
      default:        pp = '0;
    endcase
    sum_hi = acc_q[AW-1:EW] + pp;
    acc_sh = $signed({sum_hi, acc_q[EW-1:0]}) >>> 2;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = a_ext;
          mplier_d = {b_ext, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        // The cycle after the last Booth step commits the product.
        if (cnt_q == CW'(N)) begin
          product_d = acc_q[PW-1:0];
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          acc_d    = acc_sh;
          mplier_d = mplier_q >> 2;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Product = product_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Scoreboard bench for booth_mult_r4 at D_IN = 5, 8 and 16, sharing one handshake sequencer.
module tb_booth_mult_r4;

  logic        clk = 1'b0;
  logic        rst_n, start, sgn;
  logic [15:0] a_in, b_in;
  logic        busy5, done5, busy8, done8, busy16, done16;
  logic [9:0]  p5;
  logic [15:0] p8;
  logic [31:0] p16;

  always #5 clk = ~clk;

  booth_mult_r4 #(.D_IN(5)) u_m5 (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn),
    .mul_A(a_in[4:0]), .mul_B(b_in[4:0]), .busy(busy5), .done(done5), .Product(p5));
  booth_mult_r4 #(.D_IN(8)) u_m8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn),
    .mul_A(a_in[7:0]), .mul_B(b_in[7:0]), .busy(busy8), .done(done8), .Product(p8));
  booth_mult_r4 #(.D_IN(16)) u_m16 (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn),
    .mul_A(a_in), .mul_B(b_in), .busy(busy16), .done(done16), .Product(p16));

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] q5[$];
  logic [31:0] q8[$];
  logic [31:0] q16[$];
  logic [31:0] last_exp8 = '0;
  logic pd5 = 1'b0, pd8 = 1'b0, pd16 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: interpret operands at width w as signed or unsigned, multiply, keep 2w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic s,
                                          input logic [15:0] a, input logic [15:0] b);
    longint m, av, bv;
    m  = longint'(1) << w;
    av = longint'(a) & (m - 1);
    bv = longint'(b) & (m - 1);
    if (s && av >= m / 2) av -= m;
    if (s && bv >= m / 2) bv -= m;
    return 32'((av * bv) & (m * m - 1));
  endfunction

  // Monitors: each rising done pops one expected product.
  always @(negedge clk) begin
    if (done5 && !pd5) begin
      if (q5.size() == 0) begin n_checks++; $display("FAIL done5 unexpected: got %h", p5); end
      else check("prod5", 32'(p5), q5.pop_front());
    end
    pd5 = done5;
  end
  always @(negedge clk) begin
    if (done8 && !pd8) begin
      if (q8.size() == 0) begin n_checks++; $display("FAIL done8 unexpected: got %h", p8); end
      else check("prod8", 32'(p8), q8.pop_front());
    end
    pd8 = done8;
  end
  always @(negedge clk) begin
    if (done16 && !pd16) begin
      if (q16.size() == 0) begin n_checks++; $display("FAIL done16 unexpected: got %h", p16); end
      else check("prod16", p16, q16.pop_front());
    end
    pd16 = done16;
  end

  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input bit use_exp, input logic [15:0] exp8,
                        input int hold, input bit chk_lat);
    int l5 = 0, l8 = 0, l16 = 0;
    logic [31:0] e8;
    e8 = use_exp ? {16'h0, exp8} : ref_mul(8, s, a, b);
    q5.push_back(ref_mul(5, s, a, b));
    q8.push_back(e8);
    q16.push_back(ref_mul(16, s, a, b));
    @(negedge clk);
    sgn = s; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30 && (l5 == 0 || l8 == 0 || l16 == 0); c++) begin
      #1;
      a_in = 16'($urandom); b_in = 16'($urandom); sgn = ~sgn;
      @(posedge clk); #1;
      if (chk_lat && c == 2) check("p8 held in calc", 32'(p8), last_exp8);
      if (done5  && l5  == 0) l5  = c;
      if (done8  && l8  == 0) l8  = c;
      if (done16 && l16 == 0) l16 = c;
    end
    if (l5 == 0 || l8 == 0 || l16 == 0) begin
      n_checks++;
      $display("FAIL done timeout: lat5=%0d lat8=%0d lat16=%0d", l5, l8, l16);
    end
    if (chk_lat) begin
      check("latency5", 32'(l5), 32'd4);
      check("latency8", 32'(l8), 32'd6);
      check("latency16", 32'(l16), 32'd10);
    end
    for (int h = 0; h < hold; h++) begin
      #1; a_in = 16'($urandom); b_in = 16'($urandom); sgn = ~sgn;
      @(posedge clk); #1;
    end
    if (hold > 0) check("held start busy/done", 32'({busy5, done5, busy8, done8, busy16, done16}), 32'h3F);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("idle after drop", 32'({busy5, done5, busy8, done8, busy16, done16}), 32'h0);
    last_exp8 = e8;
  endtask

  task automatic reset_mid_calc(input logic [15:0] a, input logic [15:0] b);
    q5.push_back(ref_mul(5, 1'b1, a, b));
    q8.push_back(ref_mul(8, 1'b1, a, b));
    q16.push_back(ref_mul(16, 1'b1, a, b));
    @(negedge clk);
    sgn = 1'b1; a_in = a; b_in = b; start = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("reset busy8", 32'(busy8), 32'h0);
    check("reset done8", 32'(done8), 32'h0);
    check("reset product8", 32'(p8), 32'h0);
    check("reset all16", {done16, busy16, p16[29:0]}, 32'h0);
    void'(q5.pop_back());
    void'(q8.pop_back());
    void'(q16.pop_back());
    last_exp8 = '0;
    @(negedge clk) start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy8", 32'(busy8), 32'h0);
    check("rst done8", 32'(done8), 32'h0);
    check("rst product8", 32'(p8), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    run_op(1'b1, 16'd10,    16'd2,    1'b1, 16'h0014, 3, 1'b1);
    run_op(1'b1, 16'd11,    16'h00FB, 1'b1, 16'hFFC9, 2, 1'b1);
    run_op(1'b1, 16'h00FB,  16'h00F5, 1'b1, 16'h0037, 0, 1'b1);
    run_op(1'b0, 16'h00FF,  16'h00FF, 1'b1, 16'hFE01, 0, 1'b1);
    run_op(1'b1, 16'h0080,  16'h0080, 1'b1, 16'h4000, 0, 1'b1);
    run_op(1'b1, 16'h0080,  16'h007F, 1'b1, 16'hC080, 0, 1'b1);
    run_op(1'b0, 16'hFFFF,  16'hFFFF, 1'b0, 16'h0000, 0, 1'b0);
    run_op(1'b1, 16'h8000,  16'h8000, 1'b0, 16'h0000, 0, 1'b0);
    reset_mid_calc(16'h005A, 16'h00C3);
    run_op(1'b1, 16'd3,     16'd7,    1'b1, 16'h0015, 0, 1'b1);

    for (int i = 0; i < 3000; i++)
      run_op(1'($urandom), 16'($urandom), 16'($urandom), 1'b0, 16'h0000, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(q5.size() + q8.size() + q16.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
